// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the NEC infrared transmit path (and receive path):
//   - ir_state_e    : transmitter FSM states
//   - UNITS_*       : duration of each FSM state in NEC units (562.5 us)
//   - KEY_*         : command codes used by the application keypad
//   - state_units() : duration lookup for a state / current payload bit
//   - is_mark()     : true for states that drive the carrier
// ---------------------------------------------------------------------------
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HDR_MARK  = 3'd1,
    HDR_SPACE = 3'd2,
    BIT_MARK  = 3'd3,
    BIT_SPACE = 3'd4,
    STOP_MARK = 3'd5,
    GUARD     = 3'd6
  } ir_state_e;

  // Unit counter width: the longest state (GUARD) is 64 units.
  localparam int UNIT_W = 7;

  localparam logic [UNIT_W-1:0] UNITS_HDR_MARK       = 7'd16;
  localparam logic [UNIT_W-1:0] UNITS_HDR_SPACE      = 7'd8;
  localparam logic [UNIT_W-1:0] UNITS_BIT_MARK       = 7'd1;
  localparam logic [UNIT_W-1:0] UNITS_BIT_ZERO_SPACE = 7'd1;
  localparam logic [UNIT_W-1:0] UNITS_BIT_ONE_SPACE  = 7'd3;
  localparam logic [UNIT_W-1:0] UNITS_STOP_MARK      = 7'd1;
  localparam logic [UNIT_W-1:0] UNITS_GUARD          = 7'd64;

  localparam logic [7:0] KEY_UP    = 8'h18;
  localparam logic [7:0] KEY_DOWN  = 8'h52;
  localparam logic [7:0] KEY_LEFT  = 8'h08;
  localparam logic [7:0] KEY_RIGHT = 8'h5A;

  // Number of units the given state lasts; bit_val is the payload bit
  // currently being sent (only matters for BIT_SPACE).
  function automatic logic [UNIT_W-1:0] state_units(input ir_state_e st,
                                                    input logic      bit_val);
    case (st)
      HDR_MARK:  return UNITS_HDR_MARK;
      HDR_SPACE: return UNITS_HDR_SPACE;
      BIT_MARK:  return UNITS_BIT_MARK;
      BIT_SPACE: return bit_val ? UNITS_BIT_ONE_SPACE : UNITS_BIT_ZERO_SPACE;
      STOP_MARK: return UNITS_STOP_MARK;
      GUARD:     return UNITS_GUARD;
      default:   return '0;
    endcase
  endfunction

  function automatic logic is_mark(input ir_state_e st);
    return (st == HDR_MARK) || (st == BIT_MARK) || (st == STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ---------------------------------------------------------------------------
// ir_carrier_gen
// Registered 38 kHz carrier with ~1/3 duty cycle.
//   Clock   in  system clock
//   Reset_N in  asynchronous active-low reset
//   Enable  in  carrier enable for the NEXT cycle
//   Carrier out registered carrier: high for the first CARRIER_DIV/3 cycles
//               of every CARRIER_DIV-cycle period while enabled, else 0
// Enable is looked at one cycle ahead so that the registered output lines
// up exactly with the state register of the caller: the first cycle in
// which the caller is in a mark state is the first (high) carrier cycle.
// Dropping Enable clears the phase, so every new mark restarts at phase 0.
// ---------------------------------------------------------------------------
module ir_carrier_gen #(
  parameter int unsigned CARRIER_DIV = 1316
) (
  input  logic Clock,
  input  logic Reset_N,
  input  logic Enable,
  output logic Carrier
);

  localparam int unsigned PHASE_W     = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam int unsigned HIGH_CYCLES = CARRIER_DIV / 3;
  localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(HIGH_CYCLES);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CARRIER_DIV - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               carrier_q, carrier_d;

  always_comb begin
    phase_d   = '0;
    carrier_d = 1'b0;
    if (Enable) begin
      carrier_d = (phase_q < PHASE_HIGH);
      phase_d   = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      phase_q   <= '0;
      carrier_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      carrier_q <= carrier_d;
    end
  end

  assign Carrier = carrier_q;

endmodule

// File: rtl/ir_transmitter.sv
// ---------------------------------------------------------------------------
// ir_transmitter
// NEC infrared frame transmitter: header mark/space, 32 payload bits
// (Address, ~Address, Command, ~Command, each LSB first), stop mark, then
// a guard space before the next frame may start.
//   Clock     in  system clock, rising edge
//   Reset_N   in  asynchronous active-low reset
//   Start     in  frame request
//   Address   in  [7:0] NEC address, captured on accepted Start
//   Command   in  [7:0] NEC command, captured on accepted Start
//   IR_Out    out registered LED drive (carrier in marks, 0 in spaces)
//   Busy      out frame in progress (header through end of guard)
//   Done      out one-cycle pulse in the first cycle Busy is low again
//   State_Dbg out [2:0] current FSM state (ir_state_e encoding)
//
// Start/Busy handshake: Start is a level request that is accepted on any
// rising edge where Busy is low (FSM in IDLE). Busy is high from the cycle
// after acceptance until the end of GUARD. A Start sampled on the edge that
// ends GUARD is ignored because Busy was still high; in the following Done
// cycle Busy is low, so a held Start restarts the next frame immediately.
// ---------------------------------------------------------------------------
module ir_transmitter
  import ir_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 28125,
  parameter int unsigned CARRIER_DIV = 1316
) (
  input  logic       Clock,
  input  logic       Reset_N,
  input  logic       Start,
  input  logic [7:0] Address,
  input  logic [7:0] Command,
  output logic       IR_Out,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] State_Dbg
);

  // Cycle-within-unit counter plus unit counter together span 64 units
  // (the longest state) without wrapping.
  localparam int unsigned CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  ir_state_e          state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [UNIT_W-1:0]  unit_q, unit_d;
  logic [4:0]         bit_q, bit_d;
  logic [31:0]        payload_q, payload_d;
  logic               done_q, done_d;

  logic [UNIT_W-1:0]  units_now;
  logic               unit_end;
  logic               state_end;
  logic               carrier;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    unit_d    = unit_q;
    bit_d     = bit_q;
    payload_d = payload_q;
    done_d    = 1'b0;

    // payload_q[0] is always the bit currently on air; it decides the
    // BIT_SPACE length.
    units_now = state_units(state_q, payload_q[0]);
    unit_end  = (cyc_q == CYC_LAST);
    state_end = unit_end && (unit_q == units_now - 1'b1);

    case (state_q)
      IDLE: begin
        if (Start) begin
          payload_d = {~Command, Command, ~Address, Address};
          bit_d     = '0;
          cyc_d     = '0;
          unit_d    = '0;
          state_d   = HDR_MARK;
        end
      end

      default: begin
        if (unit_end) begin
          cyc_d  = '0;
          unit_d = unit_q + 1'b1;
        end else begin
          cyc_d  = cyc_q + 1'b1;
        end

        if (state_end) begin
          // Every state entry starts counting from zero.
          cyc_d  = '0;
          unit_d = '0;
          case (state_q)
            HDR_MARK:  state_d = HDR_SPACE;
            HDR_SPACE: state_d = BIT_MARK;
            BIT_MARK:  state_d = BIT_SPACE;
            BIT_SPACE: begin
              if (bit_q == 5'd31) begin
                state_d = STOP_MARK;
              end else begin
                bit_d     = bit_q + 1'b1;
                payload_d = {1'b0, payload_q[31:1]};
                state_d   = BIT_MARK;
              end
            end
            STOP_MARK: state_d = GUARD;
            GUARD: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            default:   state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      unit_q    <= '0;
      bit_q     <= '0;
      payload_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      unit_q    <= unit_d;
      bit_q     <= bit_d;
      payload_q <= payload_d;
      done_q    <= done_d;
    end
  end

  // Enable follows the next state so the carrier flop is aligned with
  // state_q: the first cycle of each mark state outputs a carrier high.
  ir_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV)
  ) u_carrier (
    .Clock  (Clock),
    .Reset_N(Reset_N),
    .Enable (is_mark(state_d)),
    .Carrier(carrier)
  );

  assign IR_Out    = carrier;
  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign State_Dbg = state_q;

endmodule

// File: tb/tb_ir_transmitter.sv
// ---------------------------------------------------------------------------
// tb_ir_transmitter
// Bench for ir_transmitter with UNIT_CYCLES=8, CARRIER_DIV=3. Expected
// frame words are queued when a Start is driven; a monitor decodes IR_Out
// mark/space widths back into a 32-bit word and compares it on each stop
// mark. Busy length and Done behaviour are checked alongside.
// ---------------------------------------------------------------------------
module tb_ir_transmitter;
  import ir_pkg::*;

  localparam int unsigned UNIT = 8;
  localparam int unsigned DIV  = 3;
  localparam int BUSY_CYCLES = 185 * UNIT;

  logic       Clock;
  logic       Reset_N;
  logic       Start;
  logic [7:0] Address;
  logic [7:0] Command;
  logic       IR_Out;
  logic       Busy;
  logic       Done;
  logic [2:0] state_dbg;

  logic [31:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  ir_transmitter #(
    .UNIT_CYCLES(UNIT),
    .CARRIER_DIV(DIV)
  ) dut (
    .Clock    (Clock),
    .Reset_N  (Reset_N),
    .Start    (Start),
    .Address  (Address),
    .Command  (Command),
    .IR_Out   (IR_Out),
    .Busy     (Busy),
    .Done     (Done),
    .State_Dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] nec_word(input logic [7:0] a,
                                           input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  // ---------------- monitor / decoder ----------------
  int cyc = 0;
  bit in_mark = 0;
  int last_one = 0;
  int mark_start = 0;
  int seg = 0;          // 0: expect header mark, 1: header space, 2: bits
  int nbits = 0;
  logic [31:0] word = '0;
  int busy_len = 0;
  int done_count = 0;

  always @(negedge Clock) begin
    int gap;
    int span;
    logic [31:0] exp_w;
    cyc++;
    if (!Reset_N) begin
      in_mark  = 0;
      seg      = 0;
      busy_len = 0;
    end else begin
      if (IR_Out) begin
        if (!in_mark) begin
          gap = cyc - last_one - 1;
          if (seg == 1) begin
            check("hdr_space_gap", gap, 65);
            seg = 2;
          end else if (seg == 2) begin
            if (nbits >= 32) begin
              check("extra_bit", nbits, 31);
            end else if (gap == 9) begin
              word[nbits] = 1'b0;
              nbits++;
            end else if (gap == 25) begin
              word[nbits] = 1'b1;
              nbits++;
            end else begin
              check("bit_space_gap", gap, 9);
              nbits++;
            end
          end
          in_mark    = 1;
          mark_start = cyc;
        end else begin
          check("carrier_period", cyc - last_one, DIV);
        end
        last_one = cyc;
      end else if (in_mark && (cyc - last_one >= 3)) begin
        in_mark = 0;
        span = last_one - mark_start + 1;
        if (seg == 0) begin
          check("hdr_mark_span", span, 127);
          seg   = 1;
          nbits = 0;
          word  = '0;
        end else if (seg == 2) begin
          check("bit_mark_span", span, 7);
          if (nbits == 32) begin
            if (exp_q.size() == 0) begin
              check("unexpected_frame", word, 32'hFFFF_FFFF);
            end else begin
              exp_w = exp_q.pop_front();
              check("frame_word", word, exp_w);
            end
            seg = 0;
          end
        end else begin
          check("mark_in_hdr_space", span, 0);
        end
      end

      if (Busy) busy_len++;
      if (Done) begin
        check("busy_len", busy_len, BUSY_CYCLES);
        check("busy_low_on_done", Busy, 1'b0);
        busy_len = 0;
        done_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the DUT idle; returns at the next negedge.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] c);
    check("idle_before_start", Busy, 1'b0);
    Address = a;
    Command = c;
    Start   = 1'b1;
    exp_q.push_back(nec_word(a, c));
    @(negedge Clock);
    Start = 1'b0;
    check("busy_after_start", Busy, 1'b1);
  endtask

  task automatic wait_done(input int budget, output int waited);
    waited = 0;
    while (Done !== 1'b1 && waited < budget) begin
      @(negedge Clock);
      waited++;
    end
    if (Done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int dc;
    logic [7:0] a;
    logic [7:0] c;

    Reset_N = 1'b0;
    Start   = 1'b0;
    Address = '0;
    Command = '0;
    repeat (3) @(negedge Clock);
    check("reset_ir_out", IR_Out, 1'b0);
    check("reset_busy", Busy, 1'b0);
    check("reset_done", Done, 1'b0);
    check("reset_state", state_dbg, 3'd0);
    Reset_N = 1'b1;
    repeat (2) @(negedge Clock);

    // Basic frame: address 0x00, command UP.
    send_frame(8'h00, KEY_UP);
    wait_done(2000, w);

    // Restart in the cycle right after Done.
    @(negedge Clock);
    send_frame(8'hA5, KEY_LEFT);
    wait_done(2000, w);
    send_frame(8'($urandom_range(0, 255)), KEY_DOWN);
    wait_done(2000, w);

    // Start during a frame is ignored; payload stays the original one.
    @(negedge Clock);
    send_frame(8'h3C, KEY_UP);
    repeat (199) @(negedge Clock);
    Command = KEY_RIGHT;
    Start   = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(2000, w);
    repeat (50) @(negedge Clock);
    check("no_second_frame", Busy, 1'b0);

    // Reset in the middle of a frame.
    send_frame(8'h77, KEY_DOWN);
    repeat (499) @(negedge Clock);
    dc = done_count;
    Reset_N = 1'b0;
    #1;
    check("abort_ir_out", IR_Out, 1'b0);
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge Clock);
    Reset_N = 1'b1;
    repeat (10) @(negedge Clock);
    check("no_done_after_abort", done_count, dc);
    check("idle_after_abort", state_dbg, 3'd0);
    a = 8'($urandom_range(0, 255));
    send_frame(a, KEY_RIGHT);
    wait_done(2000, w);

    // Start held high: three back-to-back frames.
    @(negedge Clock);
    a = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    Address = a;
    Command = c;
    Start   = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(nec_word(a, c));
    @(negedge Clock);
    check("b2b_busy_first", Busy, 1'b1);
    wait_done(2000, w);
    @(negedge Clock);
    check("b2b_busy_again", Busy, 1'b1);
    wait_done(2000, w);
    check("b2b_period", w + 1, 1481);
    @(negedge Clock);
    check("b2b_busy_third", Busy, 1'b1);
    Start = 1'b0;
    wait_done(2000, w);
    check("b2b_period", w + 1, 1481);
    repeat (20) @(negedge Clock);
    check("b2b_stopped", Busy, 1'b0);

    check("pending_frames", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
